pipelined_mult_unit: RTL
========================

// Module: pipelined_mult_unit
// PURPOSE
//  Parametrised, pipelined integer multiplier for the EX stage; successor to the single-cycle forwarding multiplier.
//  Selects each operand from its register value or the forwarded value, then multiplies signed or unsigned.
//  Carries a valid bit down a STAGES-deep pipe with stall and flush, and returns the low or high product half.
// PARAMETERS
//  WIDTH   32  operand and result width in bits (>=2)
//  STAGES  3   pipeline depth = issue-to-result latency in cycles (>=1)
// PORTS
//  clk        in   1      single clock, all state updates on the rising edge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      issue a multiply this cycle
//  x1         in   WIDTH  operand A from the register file
//  x2         in   WIDTH  operand B from the register file
//  fwd        in   WIDTH  forwarded result from a later stage
//  forwardA   in   1      1: operand A = fwd
//  forwardB   in   1      1: operand B = fwd
//  sgn        in   1      1: signed x signed; 0: unsigned x unsigned
//  hi         in   1      1: return product[2W-1:W]; 0: return product[W-1:0]
//  stall      in   1      freeze the whole pipe
//  flush      in   1      kill all in-flight operations
//  out_valid  out  1      out holds a completed result
//  out        out  WIDTH  result
//  busy       out  1      OR of all stage valid bits
// BEHAVIOUR
//  - Reset: every stage valid = 0, every stage data = 0, out = 0, out_valid = 0, busy = 0. Reset overrides stall and flush.
//  - Operand select, combinational at issue: A = forwardA ? fwd : x1; B = forwardB ? fwd : x2.
//    With both set, both operands are fwd (fwd squared).
//  - Product is 2*WIDTH bits. sgn=1 sign-extends both operands; sgn=0 zero-extends them. The low half is identical in both modes.
//  - Latency: an op issued in cycle t with stall=0 gives out_valid=1 in cycle t+STAGES. Throughput is 1 op/cycle.
//  - sgn and hi are captured at issue and travel with the op. Later changes do not affect ops already in flight.
//  - stall=1: all stage regs hold, out/out_valid hold, in_valid is ignored (not accepted). The issuer must re-present the op.
//  - flush=1 (stall=0): all valid bits clear next cycle; data regs need not clear. in_valid in the same cycle is dropped.
//  - flush=1 with stall=1: flush wins; valid bits clear.
//  - out is the last stage data reg; it holds its value when out_valid=0 (no zeroing after reset).
//  - Pipeline: stage 1 registers the selected operands and mode. The multiply result is registered at stage STAGES.
//    For STAGES=1, operands feed the multiplier directly and the result is registered once.
//  - Reset asserted mid-operation discards every in-flight op. The first op issued after reset falls follows normal latency.
// CONFIGURATION
//  - MULT_HI_EN defined: hi is honoured; the full 2*WIDTH product is built and the upper half can be selected (MULH/MULHU).
//  - MULT_HI_EN undefined: hi is ignored, out is always product[W-1:0], and only the low half is built. sgn then has no effect on out.
// TESTING (WIDTH=32, STAGES=3, MULT_HI_EN defined unless noted)
//  1. x1=7, x2=6, no fwd, sgn=0, hi=0, issue at t0 -> out_valid=1 and out=42 at t3 only.
//  2. x1=5, fwd=9, forwardA=1, forwardB=1 -> out=81. Then forwardB=1 only, x1=3, fwd=4 -> out=12.
//  3. x1=0xFFFFFFFF, x2=2, hi=1: sgn=1 -> out=0xFFFFFFFF (-2>>32); sgn=0 -> out=0x00000001.
//  4. Issue back-to-back ops A,B,C; stall for 2 cycles after B issues -> results appear in order A,B,C.
//     Results are delayed by 2 cycles; none is lost or duplicated. in_valid during stall is not accepted.
//  5. Two ops in flight, flush=1 -> busy=0 next cycle and no out_valid pulse. Same test with stall=1 gives the same result.
//  6. Reset mid-flight -> all outputs 0 next cycle. Also: MULT_HI_EN undefined with hi=1, 0xFFFFFFFF*2 -> out=0xFFFFFFFE.

Source files
------------

// File: rtl/pipelined_mult_unit.sv
// Pipelined EX-stage integer multiplier with operand forwarding, stall and flush.
// Define MULT_HI_EN to build the full 2*WIDTH product and honour hi (MULH/MULHU).
module pipelined_mult_unit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] fwd,
  input  logic             forwardA,
  input  logic             forwardB,
  input  logic             sgn,
  input  logic             hi,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_sgn;
  logic             mul_hi;
  logic             mul_valid;
  logic [WIDTH-1:0] mul_result;
  logic             ops_busy;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;

  assign sel_a = forwardA ? fwd : x1;
  assign sel_b = forwardB ? fwd : x2;

  generate
    if (STAGES == 1) begin : g_direct
      assign mul_a     = sel_a;
      assign mul_b     = sel_b;
      assign mul_sgn   = sgn;
      assign mul_hi    = hi;
      assign mul_valid = in_valid;
      assign ops_busy  = 1'b0;
    end else begin : g_ops
      localparam int N = STAGES - 1;

      logic [WIDTH-1:0] a_q [N];
      logic [WIDTH-1:0] b_q [N];
      logic [N-1:0]     sgn_q;
      logic [N-1:0]     hi_q;
      logic [N-1:0]     v_q;

      // Operand/mode stages ahead of the multiplier; flush only kills valid bits.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < N; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
          end
          sgn_q <= '0;
          hi_q  <= '0;
          v_q   <= '0;
        end else begin
          if (!stall) begin
            a_q[0]   <= sel_a;
            b_q[0]   <= sel_b;
            sgn_q[0] <= sgn;
            hi_q[0]  <= hi;
            for (int i = 1; i < N; i++) begin
              a_q[i]   <= a_q[i-1];
              b_q[i]   <= b_q[i-1];
              sgn_q[i] <= sgn_q[i-1];
              hi_q[i]  <= hi_q[i-1];
            end
          end
          if (flush) begin
            v_q <= '0;
          end else if (!stall) begin
            v_q[0] <= in_valid;
            for (int i = 1; i < N; i++) begin
              v_q[i] <= v_q[i-1];
            end
          end
        end
      end

      assign mul_a     = a_q[N-1];
      assign mul_b     = b_q[N-1];
      assign mul_sgn   = sgn_q[N-1];
      assign mul_hi    = hi_q[N-1];
      assign mul_valid = v_q[N-1];
      assign ops_busy  = |v_q;
    end
  endgenerate

`ifdef MULT_HI_EN
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;

  // Sign- or zero-extend to 2*WIDTH so one unsigned multiply serves both modes.
  assign ext_a      = {{WIDTH{mul_sgn & mul_a[WIDTH-1]}}, mul_a};
  assign ext_b      = {{WIDTH{mul_sgn & mul_b[WIDTH-1]}}, mul_b};
  assign product    = ext_a * ext_b;
  assign mul_result = mul_hi ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
`else
  logic unused_mode;

  assign unused_mode = mul_sgn ^ mul_hi;
  assign mul_result  = mul_a * mul_b;
`endif

  // Result stage: out only loads on a completing op, so it holds between results.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (!stall) begin
      res_valid <= mul_valid;
      if (mul_valid) begin
        res_data <= mul_result;
      end
    end
  end

  assign out_valid = res_valid;
  assign out       = res_data;
  assign busy      = ops_busy | res_valid;

endmodule
